// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared types and constants for the memory arbiter and its bench.
package memory_arbiter_pkg;
    localparam int NREQ = 2;
    typedef logic [31:0] memword;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin grant selection with lock bursts bounded by MAX_BURST.
module rr_picker
    import memory_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            take_i,
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] lock_i,
    input  logic            owner_i,
    output logic            grant_o
);
    localparam int CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0] burst_q, burst_d;
    logic other, rebid;
    assign other = ~owner_i;
    // a locked owner keeps the bus until its burst is spent while the other side waits
    assign rebid = req_i[owner_i] && lock_i[owner_i] && (burst_q < CW'(MAX_BURST) || !req_i[other]);
    assign grant_o = rebid ? owner_i : (req_i[other] ? other : owner_i);
    assign burst_d = !take_i ? burst_q :
                     !rebid ? '0 :
                     burst_q == CW'(MAX_BURST) ? burst_q : burst_q + CW'(1);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) burst_q <= '0;
        else burst_q <= burst_d;
    end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: two-requester arbiter (CPU, NI DMA) in front of a synchronous single-port memory.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic [NREQ-1:0]       req_in,
    input  memword [NREQ-1:0]     addr_in,
    input  memword [NREQ-1:0]     data_in,
    input  logic [NREQ-1:0][3:0]  wb_in,
    input  logic [NREQ-1:0]       lock_in,
    output logic [NREQ-1:0]       ack_out,
    output memword                rdata_out,
    output memword                mem_addr_out,
    output memword                mem_data_out,
    output logic [3:0]            mem_wb_out,
    input  memword                mem_data_in,
    output logic                  owner_out,
    output logic                  busy_out
);
    arb_state_t state_q;
    memword addr_q, data_q;
    logic [3:0] wb_q;
    logic [NREQ-1:0] ack_q;
    logic owner_q, grant, take;
    assign take = (state_q == IDLE) && (|req_in);
    rr_picker #(.MAX_BURST(MAX_BURST)) u_pick (
        .clk_i   (clock_in),
        .rst_i   (reset_in),
        .take_i  (take),
        .req_i   (req_in),
        .lock_i  (lock_in),
        .owner_i (owner_q),
        .grant_o (grant)
    );
    // owner resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            ack_q   <= '0;
            wb_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            owner_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (take) begin
                    state_q <= ISSUE;
                    owner_q <= grant;
                    addr_q  <= addr_in[grant];
                    data_q  <= data_in[grant];
                    wb_q    <= wb_in[grant];
                end
                ISSUE: begin
                    state_q        <= RESP;
                    wb_q           <= '0;
                    ack_q[owner_q] <= 1'b1;
                end
                RESP: begin
                    state_q <= IDLE;
                    ack_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign ack_out      = ack_q;
    assign rdata_out    = (state_q == RESP) ? mem_data_in : '0;
    assign mem_addr_out = addr_q;
    assign mem_data_out = data_q;
    assign mem_wb_out   = wb_q;
    assign owner_out    = owner_q;
    assign busy_out     = state_q != IDLE;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed vector table plus hand-written burst, alternation and reset sequences.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;
    logic                 clock_in, reset_in;
    logic [1:0]           req_in, lock_in, ack_out;
    memword [1:0]         addr_in, data_in;
    logic [1:0][3:0]      wb_in;
    memword               rdata_out, mem_addr_out, mem_data_out, mem_data_in;
    logic [3:0]           mem_wb_out;
    logic                 owner_out, busy_out;
    int n_chk = 0, n_fail = 0;

    memory_arbiter #(.MAX_BURST(4)) dut (
        .clock_in(clock_in), .reset_in(reset_in), .req_in(req_in), .addr_in(addr_in),
        .data_in(data_in), .wb_in(wb_in), .lock_in(lock_in), .ack_out(ack_out),
        .rdata_out(rdata_out), .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
        .mem_wb_out(mem_wb_out), .mem_data_in(mem_data_in), .owner_out(owner_out),
        .busy_out(busy_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    logic [31:0] mem [256] = '{default: '0};
    logic loaded = 1'b0;
    always @(posedge clock_in) begin
        if (!loaded) begin
            mem[16] <= 32'hDEADBEEF;
            loaded  <= 1'b1;
        end
        for (int b = 0; b < 4; b++)
            if (mem_wb_out[b]) mem[mem_addr_out[7:0]][8*b +: 8] <= mem_data_out[8*b +: 8];
        mem_data_in <= mem[mem_addr_out[7:0]];
    end

    typedef struct {
        logic [1:0]  req, lock;
        logic [31:0] a0, a1, d0, d1;
        logic [3:0]  w0, w1;
        logic [1:0]  ack;
        logic        rdc;
        logic [31:0] rd;
        logic [3:0]  wb;
        logic        owner;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int n = 0, wbc = 0;
        logic [3:0] wbv = '0;
        logic [1:0] a = '0;
        logic [31:0] rd = '0;
        req_in = v.req; lock_in = v.lock;
        addr_in[0] = v.a0; addr_in[1] = v.a1;
        data_in[0] = v.d0; data_in[1] = v.d1;
        wb_in[0] = v.w0; wb_in[1] = v.w1;
        while (a == 2'b00 && n < 10) begin
            @(posedge clock_in); #1;
            n++;
            if (mem_wb_out != 4'h0) begin wbc++; wbv = mem_wb_out; end
            if (ack_out != 2'b00) begin a = ack_out; rd = rdata_out; end
        end
        chk({nm, "_latency"}, n, 2);
        chk({nm, "_ack"}, a, v.ack);
        chk({nm, "_owner"}, owner_out, v.owner);
        chk({nm, "_wb_cycles"}, wbc, (v.wb != 4'h0) ? 1 : 0);
        chk({nm, "_wb_value"}, wbv, v.wb);
        if (v.rdc) chk({nm, "_rdata"}, rd, v.rd);
        req_in = '0; lock_in = '0; wb_in = '0;
        @(posedge clock_in); #1;
    endtask

    logic [1:0] got [16];
    int nack, dual;
    task automatic wait_acks(input string nm, input int n);
        int cyc = 0;
        nack = 0;
        while (nack < n && cyc < 200) begin
            @(posedge clock_in); #1;
            cyc++;
            if (ack_out == 2'b11) dual++;
            if (ack_out != 2'b00) begin got[nack] = ack_out; nack++; end
        end
        chk({nm, "_ack_count"}, nack, n);
    endtask

    task automatic do_reset(input logic [1:0] r, input logic [1:0] l);
        reset_in = 1'b1; req_in = '0; lock_in = '0; wb_in = '0;
        @(posedge clock_in); #1;
        req_in = r; lock_in = l;
        reset_in = 1'b0;
    endtask

    initial begin
        vec_t v;
        logic [1:0] exp_b [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        tbl[0]  = '{2'b01, 2'b00, 32'h10, 32'h0,  32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 1'b1, 32'hDEADBEEF, 4'h0, 1'b0};
        tbl[1]  = '{2'b10, 2'b00, 32'h0,  32'h20, 32'h0,        32'h12345678, 4'h0, 4'hF, 2'b10, 1'b0, 32'h0,        4'hF, 1'b1};
        tbl[2]  = '{2'b10, 2'b00, 32'h0,  32'h20, 32'h0,        32'h000000AA, 4'h0, 4'h1, 2'b10, 1'b0, 32'h0,        4'h1, 1'b1};
        tbl[3]  = '{2'b10, 2'b00, 32'h0,  32'h20, 32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 1'b1, 32'h123456AA, 4'h0, 1'b1};
        tbl[4]  = '{2'b11, 2'b00, 32'h20, 32'h10, 32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 1'b1, 32'h123456AA, 4'h0, 1'b0};
        tbl[5]  = '{2'b11, 2'b00, 32'h20, 32'h10, 32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 1'b1, 32'hDEADBEEF, 4'h0, 1'b1};
        tbl[6]  = '{2'b11, 2'b01, 32'h10, 32'h20, 32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 1'b1, 32'hDEADBEEF, 4'h0, 1'b0};
        tbl[7]  = '{2'b11, 2'b01, 32'h20, 32'h10, 32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 1'b1, 32'h123456AA, 4'h0, 1'b0};
        tbl[8]  = '{2'b10, 2'b01, 32'h0,  32'h30, 32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 1'b1, 32'h0,        4'h0, 1'b1};
        tbl[9]  = '{2'b01, 2'b00, 32'h40, 32'h0,  32'hCAFEF00D, 32'h0,        4'hC, 4'h0, 2'b01, 1'b0, 32'h0,        4'hC, 1'b0};
        tbl[10] = '{2'b01, 2'b00, 32'h40, 32'h0,  32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 1'b1, 32'hCAFE0000, 4'h0, 1'b0};
        reset_in = 1'b1; req_in = '0; lock_in = '0; addr_in = '0; data_in = '0; wb_in = '0;
        @(posedge clock_in); #1;
        chk("reset_ack", ack_out, 2'b00);
        chk("reset_rdata", rdata_out, 32'h0);
        chk("reset_wb", mem_wb_out, 4'h0);
        chk("reset_busy", busy_out, 1'b0);
        chk("reset_owner", owner_out, 1'b1);
        chk("reset_addr", mem_addr_out, 32'h0);
        chk("reset_data", mem_data_out, 32'h0);
        reset_in = 1'b0;
        @(posedge clock_in); #1;
        for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        req_in = 2'b01; addr_in[0] = 32'h30; data_in[0] = 32'hFFFFFFFF; wb_in[0] = 4'hF;
        @(posedge clock_in); #1;
        chk("rst_mid_busy_before", busy_out, 1'b1);
        chk("rst_mid_wb_before", mem_wb_out, 4'hF);
        #2 reset_in = 1'b1;
        #1;
        chk("rst_mid_wb", mem_wb_out, 4'h0);
        chk("rst_mid_busy", busy_out, 1'b0);
        chk("rst_mid_ack", ack_out, 2'b00);
        @(posedge clock_in); #1;
        req_in = '0; wb_in = '0; reset_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock_in); #1;
            chk($sformatf("rst_no_ack%0d", i), ack_out, 2'b00);
        end
        v = '{2'b01, 2'b00, 32'h30, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 1'b1, 32'h0, 4'h0, 1'b0};
        run_vec("after_rst", v);

        do_reset(2'b11, 2'b00);
        dual = 0;
        wait_acks("alt", 6);
        for (int i = 0; i < 6; i++) chk($sformatf("alt%0d", i), got[i], (i % 2 == 1) ? 2'b10 : 2'b01);
        chk("alt_no_dual", dual, 0);

        do_reset(2'b11, 2'b10);
        dual = 0;
        wait_acks("burst", 6);
        for (int i = 0; i < 6; i++) chk($sformatf("burst%0d", i), got[i], exp_b[i]);
        chk("burst_no_dual", dual, 0);

        do_reset(2'b10, 2'b10);
        wait_acks("sat_solo", 10);
        for (int i = 0; i < 10; i++) chk($sformatf("sat_solo%0d", i), got[i], 2'b10);
        req_in = 2'b11;
        wait_acks("sat_switch", 1);
        chk("sat_switch", got[0], 2'b01);
        req_in = '0; lock_in = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: MAX_BURST, 8, max consecutive locked grants to one requester while the other waits (>=1).
REQ-002 Port: clock_in  input  1  single clock; all state on rising edge.
REQ-003 Port: reset_in  input  1  reset, asynchronous, active-high.
REQ-004 Port: req_in  input  2  per-requester access request (index 0 = CPU, 1 = NI DMA).
REQ-005 Port: addr_in  input  2x32 (memword)  per-requester word address.
REQ-006 Port: data_in  input  2x32 (memword)  per-requester write data.
REQ-007 Port: wb_in  input  2x4  per-requester byte write enables; 0 = read.
REQ-008 Port: lock_in  input  2  per-requester burst lock (keep ownership).
REQ-009 Port: ack_out  output  2  one-hot completion strobe, one cycle.
REQ-010 Port: rdata_out  output  32 (memword)  read data, valid only with ack_out.
REQ-011 Port: mem_addr_out / mem_data_out  output  32 each  to memory addr_in / data_in.
REQ-012 Port: mem_wb_out  output  4  to memory wb_in.
REQ-013 Port: mem_data_in  input  32  from memory data_out (synchronous read, 1-cycle latency).
REQ-014 Port: owner_out  output  1  index of current/last granted requester; busy_out  output  1  high outside IDLE.

Function
REQ-015 FSM states IDLE, ISSUE, RESP; IDLE->ISSUE on any req_in; ISSUE->RESP unconditionally; RESP->IDLE unconditionally.
REQ-016 At the IDLE->ISSUE edge the winner's addr/data/wb are captured into registers; mem_addr_out/mem_data_out drive these registers in all states.
REQ-017 mem_wb_out equals captured wb only in ISSUE, 0 in every other state (no spurious writes).
REQ-018 In RESP ack_out[owner]=1 and rdata_out=mem_data_in; otherwise ack_out=0 and rdata_out=0; ack also issued for writes.
REQ-019 Latency: req sampled at edge E0 -> ISSUE cycle after E0 -> ack high in cycle after E1; one transaction per 3 cycles max.
REQ-020 Requester holds req/addr/data/wb stable until it samples ack; req drop during ISSUE/RESP does not abort the transaction.
REQ-021 Arbitration with one req: grant it; with both: round-robin, grant requester != owner_out.
REQ-022 Lock: if lock_in[owner] and req_in[owner] in IDLE, grant owner again and increment burst counter; counter clears on owner change or lock low.
REQ-023 When burst counter reaches MAX_BURST and other requester pending, grant the other regardless of lock; counter clears.
REQ-024 Lock by a requester not currently owner has no effect on arbitration.
REQ-025 Burst counter saturates at MAX_BURST when no competitor is pending.

Reset
REQ-026 reset_in high forces immediately: state IDLE, ack_out=0, rdata_out=0, mem_wb_out=0, captured addr/data=0, owner_out=1 (so index 0 wins first tie), burst counter 0, busy_out=0.
REQ-027 A transaction interrupted by reset is dropped without ack; first request after release is served with normal latency.

Structure
REQ-028 arb_state_t enum and NREQ=2 constant reside in the shared testbench package beside memword.
REQ-029 Memory-side ports map one-to-one onto the IMemory CON modport signals.
REQ-030 Grant selection (round-robin, lock, burst counter) is one sub-module rr_picker; FSM and capture registers stay in memory_arbiter.

Verification
REQ-031 Memory word 0x10 = 0xDEADBEEF; req_in[0] with addr 0x10, wb 0 -> ack_out=2'b01 exactly 2 cycles after sampling, rdata_out=0xDEADBEEF, mem_wb_out stays 0.
REQ-032 req_in[1] addr 0x20 data 0x12345678 wb 0xF -> mem_wb_out=0xF for exactly one cycle; then wb 0x1 data 0x000000AA -> read returns 0x123456AA.
REQ-033 Both req high continuously from reset release -> grants alternate 0,1,0,1; ack_out never 2'b11.
REQ-034 MAX_BURST=4, requester 1 locked with continuous requests, requester 0 pending -> four consecutive acks to 1, then ack to 0.
REQ-035 reset_in pulsed during ISSUE of a wb 0xF write -> mem_wb_out falls to 0 same cycle, no ack, busy_out=0; next request after release acked in 2 cycles.
